// File: rtl/fsm_flow_ctrl_pkg.sv
// Shared state encoding and threshold validation for the FIFO flow-control FSM.
package fsm_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // A usable window needs L strictly below H, and H must be reachable by a FIFO count.
  function automatic logic threshold_valid(input logic [31:0] l,
                                           input logic [31:0] h,
                                           input logic [31:0] depth);
    if ((l < h) && (h <= depth)) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/fsm_flow_ctrl_chan_thresh_cmp.sv
// Combinational count-vs-threshold comparators for one FIFO channel.
module chan_thresh_cmp #(
  parameter int CNT_W    = 5,
  parameter int UMBRAL_W = 8
) (
  input  logic [CNT_W-1:0]    count,
  input  logic [UMBRAL_W-1:0] thr_l,
  input  logic [UMBRAL_W-1:0] thr_h,
  output logic                almost_empty,
  output logic                almost_full
);

  // Compare at the wider of the two widths so neither operand is truncated.
  localparam int CMP_W = (CNT_W > UMBRAL_W) ? CNT_W : UMBRAL_W;

  logic [CMP_W-1:0] count_s;
  logic [CMP_W-1:0] thr_l_s;
  logic [CMP_W-1:0] thr_h_s;

  assign count_s      = CMP_W'(count);
  assign thr_l_s      = CMP_W'(thr_l);
  assign thr_h_s      = CMP_W'(thr_h);
  assign almost_empty = (count_s <= thr_l_s);
  assign almost_full  = (count_s >= thr_h_s);

endmodule

// File: rtl/fsm_flow_ctrl.sv
// N-channel FIFO flow-control FSM: threshold capture, idle/active tracking,
// per-channel almost-empty/full flags, pause request and sticky error.
module fsm_flow_ctrl
  import fsm_flow_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int UMBRAL_W   = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [UMBRAL_W-1:0]        umbral_L,
  input  logic [UMBRAL_W-1:0]        umbral_H,
  input  logic [NUM_FIFOS-1:0]       empty_fifo,
  input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
  input  logic [NUM_FIFOS-1:0]       fifo_ovf,
  output logic [2:0]                 state,
  output logic [UMBRAL_W-1:0]        umbral_L_out,
  output logic [UMBRAL_W-1:0]        umbral_H_out,
  output logic                       idle_out,
  output logic [NUM_FIFOS-1:0]       almost_empty,
  output logic [NUM_FIFOS-1:0]       almost_full,
  output logic                       pause,
  output logic                       error_out,
  output logic [NUM_FIFOS-1:0]       error_chan
);

  state_e                state_r;
  logic [UMBRAL_W-1:0]   umbral_l_r;
  logic [UMBRAL_W-1:0]   umbral_h_r;
  logic                  idle_r;
  logic                  error_r;
  logic                  pause_r;
  logic [NUM_FIFOS-1:0]  ae_r;
  logic [NUM_FIFOS-1:0]  af_r;
  logic [NUM_FIFOS-1:0]  error_chan_r;

  logic [NUM_FIFOS-1:0]  ae_cmp_s;
  logic [NUM_FIFOS-1:0]  af_cmp_s;
  logic                  all_empty_s;
  logic                  any_ovf_s;
  logic                  cfg_ok_s;

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_chan
    chan_thresh_cmp #(
      .CNT_W    (CNT_W),
      .UMBRAL_W (UMBRAL_W)
    ) u_cmp (
      .count        (fifo_count[i*CNT_W +: CNT_W]),
      .thr_l        (umbral_l_r),
      .thr_h        (umbral_h_r),
      .almost_empty (ae_cmp_s[i]),
      .almost_full  (af_cmp_s[i])
    );
  end

  assign all_empty_s = &empty_fifo;
  assign any_ovf_s   = |fifo_ovf;
  assign cfg_ok_s    = threshold_valid(32'(umbral_L), 32'(umbral_H), 32'(FIFO_DEPTH));

  // Outputs are registered against the state being entered, so flags always
  // match the state shown on the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_RESET;
      umbral_l_r   <= {UMBRAL_W{1'b0}};
      umbral_h_r   <= {UMBRAL_W{1'b0}};
      idle_r       <= 1'b0;
      error_r      <= 1'b0;
      pause_r      <= 1'b0;
      ae_r         <= {NUM_FIFOS{1'b0}};
      af_r         <= {NUM_FIFOS{1'b0}};
      error_chan_r <= {NUM_FIFOS{1'b0}};
    end else begin
      idle_r  <= 1'b0;
      error_r <= 1'b0;
      pause_r <= 1'b0;
      ae_r    <= {NUM_FIFOS{1'b0}};
      af_r    <= {NUM_FIFOS{1'b0}};
      case (state_r)
        ST_RESET: begin
          state_r <= ST_INIT;
        end
        ST_INIT: begin
          if (init) begin
            // Thresholds are latched even when rejected, to aid debug.
            umbral_l_r <= umbral_L;
            umbral_h_r <= umbral_H;
            if (cfg_ok_s) begin
              state_r <= ST_IDLE;
              idle_r  <= 1'b1;
              ae_r    <= {NUM_FIFOS{1'b1}};
            end else begin
              state_r      <= ST_ERROR;
              error_r      <= 1'b1;
              error_chan_r <= {NUM_FIFOS{1'b0}};
            end
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_IDLE: begin
          if (init) begin
            state_r <= ST_INIT;
          end else if (!all_empty_s) begin
            state_r <= ST_ACTIVE;
            ae_r    <= ae_cmp_s;
            af_r    <= af_cmp_s;
            pause_r <= |af_cmp_s;
          end else begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
            ae_r    <= {NUM_FIFOS{1'b1}};
          end
        end
        ST_ACTIVE: begin
          if (any_ovf_s) begin
            state_r      <= ST_ERROR;
            error_r      <= 1'b1;
            error_chan_r <= fifo_ovf;
          end else if (all_empty_s) begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
            ae_r    <= {NUM_FIFOS{1'b1}};
          end else begin
            state_r <= ST_ACTIVE;
            ae_r    <= ae_cmp_s;
            af_r    <= af_cmp_s;
            pause_r <= |af_cmp_s;
          end
        end
        ST_ERROR: begin
          state_r <= ST_ERROR;
          error_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RESET;
        end
      endcase
    end
  end

  assign state        = state_r;
  assign umbral_L_out = umbral_l_r;
  assign umbral_H_out = umbral_h_r;
  assign idle_out     = idle_r;
  assign almost_empty = ae_r;
  assign almost_full  = af_r;
  assign pause        = pause_r;
  assign error_out    = error_r;
  assign error_chan   = error_chan_r;

endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Scoreboard bench for fsm_flow_ctrl: the driver queues hand-computed expected
// outputs per clock, and a monitor pops and compares them after each edge.
module tb_fsm_flow_ctrl;

  localparam int NF = 8;
  localparam int CW = $clog2(16 + 1);

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] ul;
    logic [7:0] uh;
    logic       idle;
    logic [7:0] ae;
    logic [7:0] af;
    logic       pause;
    logic       err;
    logic [7:0] ech;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              init;
  logic [7:0]        umbral_L;
  logic [7:0]        umbral_H;
  logic [NF-1:0]     empty_fifo;
  logic [NF*CW-1:0]  fifo_count;
  logic [NF-1:0]     fifo_ovf;
  logic [2:0]        state;
  logic [7:0]        umbral_L_out;
  logic [7:0]        umbral_H_out;
  logic              idle_out;
  logic [NF-1:0]     almost_empty;
  logic [NF-1:0]     almost_full;
  logic              pause;
  logic              error_out;
  logic [NF-1:0]     error_chan;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  fsm_flow_ctrl #(.NUM_FIFOS(NF), .FIFO_DEPTH(16), .UMBRAL_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_L     (umbral_L),
    .umbral_H     (umbral_H),
    .empty_fifo   (empty_fifo),
    .fifo_count   (fifo_count),
    .fifo_ovf     (fifo_ovf),
    .state        (state),
    .umbral_L_out (umbral_L_out),
    .umbral_H_out (umbral_H_out),
    .idle_out     (idle_out),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .pause        (pause),
    .error_out    (error_out),
    .error_chan   (error_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [7:0] ul, input logic [7:0] uh,
                              input logic idle, input logic [7:0] ae, input logic [7:0] af,
                              input logic pz, input logic err, input logic [7:0] ech);
    exp_t e;
    e.st = st; e.ul = ul; e.uh = uh; e.idle = idle; e.ae = ae; e.af = af;
    e.pause = pz; e.err = err; e.ech = ech;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the expectation for the coming edge, then advance to the next negedge.
  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_counts(input int base);
    for (int i = 0; i < NF; i++) fifo_count[i*CW +: CW] = CW'(base);
  endtask

  task automatic set_count(input int ch, input int v);
    fifo_count[ch*CW +: CW] = CW'(v);
  endtask

  // Monitor: compare every output after each edge against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state",        32'(state),        32'(e.st));
      chk("umbral_L_out", 32'(umbral_L_out), 32'(e.ul));
      chk("umbral_H_out", 32'(umbral_H_out), 32'(e.uh));
      chk("idle_out",     32'(idle_out),     32'(e.idle));
      chk("almost_empty", 32'(almost_empty), 32'(e.ae));
      chk("almost_full",  32'(almost_full),  32'(e.af));
      chk("pause",        32'(pause),        32'(e.pause));
      chk("error_out",    32'(error_out),    32'(e.err));
      chk("error_chan",   32'(error_chan),   32'(e.ech));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; init = 1'b0; umbral_L = 8'd0; umbral_H = 8'd0;
    empty_fifo = 8'hFF; fifo_count = '0; fifo_ovf = 8'h00;
    @(negedge clk);

    // Reset held, then released with init low: RESET -> INIT and hold.
    step(mk(3'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    step(mk(3'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step(mk(3'd1, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));

    // Valid configuration L=2, H=12.
    init = 1'b1; umbral_L = 8'd2; umbral_H = 8'd12;
    step(mk(3'd2, 8'd2, 8'd12, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b0;

    // IDLE -> ACTIVE: ch0=13 (full), ch3=1 (empty), others 5.
    empty_fifo = 8'b0101_0110; set_counts(5); set_count(0, 13); set_count(3, 1);
    step(mk(3'd3, 8'd2, 8'd12, 1'b0, 8'h08, 8'h01, 1'b1, 1'b0, 8'h00));
    // Boundaries: count == L and count == H.
    set_counts(6); set_count(1, 2); set_count(2, 12);
    step(mk(3'd3, 8'd2, 8'd12, 1'b0, 8'h02, 8'h04, 1'b1, 1'b0, 8'h00));
    // init ignored in ACTIVE; mid-range counts give no flags.
    init = 1'b1; set_counts(6);
    step(mk(3'd3, 8'd2, 8'd12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b0;

    // All empty -> IDLE, then reconfigure L=1, H=15 through INIT.
    empty_fifo = 8'hFF;
    step(mk(3'd2, 8'd2, 8'd12, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b1; umbral_L = 8'd1; umbral_H = 8'd15;
    step(mk(3'd1, 8'd2, 8'd12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    step(mk(3'd2, 8'd1, 8'd15, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b0;

    // ACTIVE with new thresholds: ch0=15 hits H, others at L=1.
    empty_fifo = 8'hFE; set_counts(1); set_count(0, 15);
    step(mk(3'd3, 8'd1, 8'd15, 1'b0, 8'hFE, 8'h01, 1'b1, 1'b0, 8'h00));
    // Overflow together with all-empty: overflow wins.
    empty_fifo = 8'hFF; fifo_ovf = 8'h20;
    step(mk(3'd4, 8'd1, 8'd15, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h20));
    // Sticky ERROR: further ovf and init are ignored.
    for (int k = 0; k < 4; k++) begin
      init = k[0]; fifo_ovf = 8'h03; empty_fifo = 8'h00;
      step(mk(3'd4, 8'd1, 8'd15, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h20));
    end
    init = 1'b0; fifo_ovf = 8'h00; empty_fifo = 8'hFF;

    // Reset exits ERROR; invalid config L=14, H=14.
    reset = 1'b0;
    step(mk(3'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    reset = 1'b1;
    step(mk(3'd1, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b1; umbral_L = 8'd14; umbral_H = 8'd14;
    step(mk(3'd4, 8'd14, 8'd14, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00));
    for (int k = 0; k < 10; k++) begin
      init = k[0]; fifo_ovf = 8'hFF; empty_fifo = 8'h0F;
      step(mk(3'd4, 8'd14, 8'd14, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00));
    end
    init = 1'b0; fifo_ovf = 8'h00; empty_fifo = 8'hFF;

    // Invalid config H=20 beyond depth 16.
    reset = 1'b0;
    step(mk(3'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    reset = 1'b1;
    step(mk(3'd1, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b1; umbral_L = 8'd3; umbral_H = 8'd20;
    step(mk(3'd4, 8'd3, 8'd20, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00));
    init = 1'b0;

    // Boundary valid config H == depth, then reset mid-ACTIVE clears everything.
    reset = 1'b0;
    step(mk(3'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    reset = 1'b1;
    step(mk(3'd1, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b1; umbral_L = 8'd4; umbral_H = 8'd16;
    step(mk(3'd2, 8'd4, 8'd16, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00));
    init = 1'b0; empty_fifo = 8'h7F; set_counts(8); set_count(7, 16); set_count(6, 4);
    step(mk(3'd3, 8'd4, 8'd16, 1'b0, 8'h40, 8'h80, 1'b1, 1'b0, 8'h00));
    reset = 1'b0;
    step(mk(3'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));
    reset = 1'b1;
    step(mk(3'd1, 8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00));

    // Drain: every queued expectation must have been consumed.
    repeat (2) @(posedge clk);
    #5;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
